// File: rtl/axis_pkg.sv
// ============================================================================
// Module      : axis_pkg
// Description : Shared AXI-Stream forward (mosi) and backward (miso) channel types.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package axis_pkg;

    localparam int AXIS_DATA_W = 32;

    typedef struct packed {
        logic                   tvalid;
        logic [AXIS_DATA_W-1:0] tdata;
        logic                   tlast;
    } axis_mosi_t;

    typedef struct packed {
        logic tready;
    } axis_miso_t;

endpackage

`default_nettype wire

// File: rtl/router_sched_pkg.sv
// ============================================================================
// Module      : router_sched_pkg
// Description : Scheduler state encoding and the round-robin pick function.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package router_sched_pkg;

    localparam int unsigned RR_MAX_CH = 32;
    localparam int unsigned RR_IDX_W  = 5;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } sched_state_e;

    // First set bit of req searching ptr+1, ptr+2, ... modulo ch; 0 when none.
    function automatic int unsigned rr_next(input logic [RR_MAX_CH-1:0] req,
                                            input int unsigned          ptr,
                                            input int unsigned          ch);
        int unsigned idx;
        int unsigned pick;
        logic        found;
        pick  = 0;
        found = 1'b0;
        for (int unsigned off = 1; off <= RR_MAX_CH; off++) begin
            if (off <= ch && !found) begin
                idx = ptr + off;
                if (idx >= ch) idx = idx - ch;
                if (req[idx[RR_IDX_W-1:0]]) begin
                    pick  = idx;
                    found = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_priority_picker.sv
// ============================================================================
// Module      : rr_priority_picker
// Description : Combinational round-robin picker starting after ptr_i.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_priority_picker
    import router_sched_pkg::*;
#(
    parameter int CHANNEL_NUMBER = 5,
    localparam int CH_W          = $clog2(CHANNEL_NUMBER)
) (
    input  logic [CHANNEL_NUMBER-1:0] req_i,
    input  logic [CH_W-1:0]           ptr_i,
    output logic [CH_W-1:0]           idx_o,
    output logic                      any_o
);

    assign any_o = |req_i;
    assign idx_o = CH_W'(rr_next(RR_MAX_CH'(req_i), 32'(ptr_i), CHANNEL_NUMBER));

endmodule

`default_nettype wire

// File: rtl/packet_rr_scheduler.sv
// ============================================================================
// Module      : packet_rr_scheduler
// Description : Packet-granular round-robin AXI-Stream scheduler; the optional
//               stall watchdog is built when ARB_WATCHDOG_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module packet_rr_scheduler
    import axis_pkg::*;
    import router_sched_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int CHANNEL_NUMBER = 5,
    parameter int TIMEOUT_CYCLES = 256,
    localparam int CH_W          = $clog2(CHANNEL_NUMBER)
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  axis_mosi_t in_mosi_i [CHANNEL_NUMBER],
    output axis_miso_t in_miso_o [CHANNEL_NUMBER],
    output axis_mosi_t out_mosi_o,
    input  axis_miso_t out_miso_i,
    output logic [CH_W-1:0] grant_o,
    output logic       busy_o,
    output logic       wd_err_o
);

    sched_state_e              state_q, state_d;
    logic [CH_W-1:0]           grant_q, grant_d;
    logic [CH_W-1:0]           ptr_q, ptr_d;
    logic [CHANNEL_NUMBER-1:0] req;
    logic [CH_W-1:0]           pick_idx;
    logic                      pick_any;
    axis_mosi_t                sel;
    logic                      sel_fire;

    for (genvar i = 0; i < CHANNEL_NUMBER; i++) begin : g_req
        assign req[i] = in_mosi_i[i].tvalid;
    end

    rr_priority_picker #(
        .CHANNEL_NUMBER(CHANNEL_NUMBER)
    ) u_picker (
        .req_i (req),
        .ptr_i (ptr_q),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    assign sel      = in_mosi_i[grant_q];
    assign sel_fire = sel.tvalid && out_miso_i.tready;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d = pick_idx;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (sel_fire && sel.tlast) begin
                    ptr_d   = grant_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset ptr to the last channel so the first search starts at channel 0.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= CH_W'(CHANNEL_NUMBER - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        out_mosi_o = '0;
        if (state_q == LOCKED) begin
            out_mosi_o.tvalid                = sel.tvalid;
            out_mosi_o.tlast                 = sel.tlast;
            out_mosi_o.tdata[DATA_WIDTH-1:0] = sel.tdata[DATA_WIDTH-1:0];
        end
    end

    for (genvar i = 0; i < CHANNEL_NUMBER; i++) begin : g_tready
        assign in_miso_o[i].tready = (state_q == LOCKED) && (grant_q == CH_W'(i))
                                     && out_miso_i.tready;
    end

    assign grant_o = grant_q;
    assign busy_o  = (state_q == LOCKED);

`ifdef ARB_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] stall_q, stall_d;
    logic            wd_err_q, wd_err_d;

    // The lock is never broken here; the error is only reported.
    always_comb begin
        stall_d  = stall_q;
        wd_err_d = wd_err_q;
        if (state_q == IDLE) begin
            if (state_d == LOCKED) stall_d = '0;
        end else if (sel_fire) begin
            stall_d = '0;
        end else if (!sel.tvalid && stall_q != WD_LIMIT) begin
            stall_d = stall_q + 1'b1;
        end
        if (stall_d == WD_LIMIT) wd_err_d = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stall_q  <= '0;
            wd_err_q <= 1'b0;
        end else begin
            stall_q  <= stall_d;
            wd_err_q <= wd_err_d;
        end
    end

    assign wd_err_o = wd_err_q;
`else
    assign wd_err_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_packet_rr_scheduler.sv
// ============================================================================
// Module      : tb_packet_rr_scheduler
// Description : Directed self-checking bench for packet_rr_scheduler (ARB_WATCHDOG_EN aware).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_packet_rr_scheduler;
    import axis_pkg::*;

    localparam int CH   = 5;
    localparam int CH_W = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    axis_mosi_t in_mosi [CH];
    axis_miso_t in_miso [CH];
    axis_mosi_t out_mosi;
    axis_miso_t out_miso;
    logic [CH_W-1:0] grant;
    logic       busy;
    logic       wd_err;

    int checks = 0;
    int errors = 0;

    int   pkts_left [CH];
    int   beat [CH];
    int   len [CH];
    int   pkt [CH];
    logic fire [CH];
    logic use_model = 1'b1;
    logic [31:0] got [$];

    always #5 clk = ~clk;

    packet_rr_scheduler #(
        .DATA_WIDTH     (32),
        .CHANNEL_NUMBER (CH),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .in_mosi_i  (in_mosi),
        .in_miso_o  (in_miso),
        .out_mosi_o (out_mosi),
        .out_miso_i (out_miso),
        .grant_o    (grant),
        .busy_o     (busy),
        .wd_err_o   (wd_err)
    );

    function automatic logic [31:0] beat_data(int c, int p, int b);
        return {8'(c), 8'(p), 16'(b)};
    endfunction

    task automatic drive_sources();
        if (use_model) begin
            for (int c = 0; c < CH; c++) begin
                in_mosi[c].tvalid = (pkts_left[c] > 0);
                in_mosi[c].tdata  = beat_data(c, pkt[c], beat[c]);
                in_mosi[c].tlast  = (beat[c] == len[c] - 1);
            end
        end
    endtask

    task automatic set_src(int c, int n, int l);
        pkts_left[c] = n;
        len[c]       = l;
        beat[c]      = 0;
        pkt[c]       = 0;
        drive_sources();
    endtask

    // One clock: capture handshakes, advance past the edge, let sources react.
    task automatic cycle();
        for (int c = 0; c < CH; c++) fire[c] = in_mosi[c].tvalid && in_miso[c].tready;
        if (out_mosi.tvalid && out_miso.tready) got.push_back(out_mosi.tdata);
        @(posedge clk);
        #1;
        if (use_model) begin
            for (int c = 0; c < CH; c++) begin
                if (fire[c]) begin
                    if (beat[c] == len[c] - 1) begin
                        beat[c] = 0;
                        pkt[c]++;
                        pkts_left[c]--;
                    end else begin
                        beat[c]++;
                    end
                end
            end
        end
        drive_sources();
        #1;
    endtask

    task automatic do_reset();
        rst_n           = 1'b0;
        use_model       = 1'b1;
        out_miso.tready = 1'b1;
        for (int c = 0; c < CH; c++) set_src(c, 0, 1);
        got.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (grant !== 3'd0) begin errors++; $display("FAIL reset_grant got %0d want 0", grant); end
        checks++; if (out_mosi.tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b want 0", out_mosi.tvalid); end
        checks++; if (wd_err !== 1'b0) begin errors++; $display("FAIL reset_wd_err got %b want 0", wd_err); end
        for (int c = 0; c < CH; c++) begin
            checks++;
            if (in_miso[c].tready !== 1'b0) begin errors++; $display("FAIL reset_tready ch%0d got %b want 0", c, in_miso[c].tready); end
        end
    endtask

    task automatic test_single_packet();
        set_src(2, 1, 3);
        #1;
        checks++; if (in_miso[2].tready !== 1'b0) begin errors++; $display("FAIL idle_tready got %b want 0", in_miso[2].tready); end
        for (int b = 0; b < 3; b++) begin
            cycle();
            checks++; if (busy !== 1'b1 || grant !== 3'd2) begin errors++; $display("FAIL single_grant beat%0d got busy=%b grant=%0d want busy=1 grant=2", b, busy, grant); end
            checks++; if (out_mosi.tvalid !== 1'b1 || out_mosi.tdata !== beat_data(2, 0, b) || out_mosi.tlast !== (b == 2)) begin
                errors++; $display("FAIL single_beat%0d got v=%b d=%h l=%b want v=1 d=%h l=%b", b, out_mosi.tvalid, out_mosi.tdata, out_mosi.tlast, beat_data(2, 0, b), (b == 2)); end
        end
        cycle();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_release got busy=%b want 0", busy); end
        checks++; if (got.size() !== 3) begin errors++; $display("FAIL single_count got %0d want 3", got.size()); end
    endtask

    task automatic test_round_robin();
        logic        eb [12] = '{1, 1, 0, 1, 1, 0, 1, 1, 0, 1, 1, 0};
        int          eg [12] = '{0, 0, 0, 1, 1, 0, 4, 4, 0, 0, 0, 0};
        logic [31:0] ed [8];
        do_reset();
        ed = '{beat_data(0, 0, 0), beat_data(0, 0, 1), beat_data(1, 0, 0), beat_data(1, 0, 1),
               beat_data(4, 0, 0), beat_data(4, 0, 1), beat_data(0, 1, 0), beat_data(0, 1, 1)};
        set_src(0, 2, 2);
        set_src(1, 1, 2);
        set_src(4, 1, 2);
        for (int i = 0; i < 12; i++) begin
            cycle();
            checks++; if (busy !== eb[i]) begin errors++; $display("FAIL rr_busy cyc%0d got %b want %b", i, busy, eb[i]); end
            if (eb[i]) begin
                checks++; if (grant !== CH_W'(eg[i]) || out_mosi.tdata[31:24] !== 8'(eg[i])) begin
                    errors++; $display("FAIL rr_grant cyc%0d got grant=%0d src=%0d want %0d", i, grant, out_mosi.tdata[31:24], eg[i]); end
            end
        end
        checks++; if (got.size() !== 8) begin errors++; $display("FAIL rr_count got %0d want 8", got.size()); end
        for (int i = 0; i < 8 && i < got.size(); i++) begin
            checks++; if (got[i] !== ed[i]) begin errors++; $display("FAIL rr_data beat%0d got %h want %h", i, got[i], ed[i]); end
        end
    endtask

    task automatic test_hold_off();
        logic eb [6] = '{1, 1, 1, 0, 1, 0};
        int   eg [6] = '{1, 1, 1, 0, 3, 0};
        logic et [6] = '{0, 0, 0, 0, 1, 0};
        got.delete();
        set_src(1, 1, 3);
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (i == 0) begin
                set_src(3, 1, 1);
                #1;
            end
            checks++; if (busy !== eb[i] || (eb[i] && grant !== CH_W'(eg[i]))) begin
                errors++; $display("FAIL hold_grant cyc%0d got busy=%b grant=%0d want busy=%b grant=%0d", i, busy, grant, eb[i], eg[i]); end
            checks++; if (in_miso[3].tready !== et[i]) begin errors++; $display("FAIL hold_tready3 cyc%0d got %b want %b", i, in_miso[3].tready, et[i]); end
        end
    endtask

    task automatic test_backpressure();
        int k = 0;
        got.delete();
        set_src(2, 1, 4);
        cycle();
        while (busy === 1'b1 && k < 20) begin
            out_miso.tready = (k % 2 == 0);
            #1;
            checks++; if (in_miso[2].tready !== out_miso.tready) begin errors++; $display("FAIL bp_tready cyc%0d got %b want %b", k, in_miso[2].tready, out_miso.tready); end
            cycle();
            k++;
        end
        out_miso.tready = 1'b1;
        checks++; if (k !== 7) begin errors++; $display("FAIL bp_cycles got %0d want 7", k); end
        checks++; if (got.size() !== 4) begin errors++; $display("FAIL bp_count got %0d want 4", got.size()); end
        for (int b = 0; b < 4 && b < got.size(); b++) begin
            checks++; if (got[b] !== beat_data(2, 0, b)) begin errors++; $display("FAIL bp_data beat%0d got %h want %h", b, got[b], beat_data(2, 0, b)); end
        end
    endtask

    task automatic test_async_reset();
        set_src(1, 1, 4);
        cycle();
        cycle();
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || grant !== 3'd0) begin errors++; $display("FAIL arst_state got busy=%b grant=%0d want 0 0", busy, grant); end
        checks++; if (out_mosi.tvalid !== 1'b0 || in_miso[1].tready !== 1'b0) begin
            errors++; $display("FAIL arst_outputs got tvalid=%b tready1=%b want 0 0", out_mosi.tvalid, in_miso[1].tready); end
        for (int c = 0; c < CH; c++) set_src(c, 1, 1);
        #1;
        rst_n = 1'b1;
        cycle();
        checks++; if (busy !== 1'b1 || grant !== 3'd0) begin errors++; $display("FAIL arst_first_grant got busy=%b grant=%0d want 1 0", busy, grant); end
        repeat (12) cycle();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_drain got busy=%b want 0", busy); end
    endtask

    task automatic test_watchdog();
        logic wd_exp;
`ifdef ARB_WATCHDOG_EN
        wd_exp = 1'b1;
`else
        wd_exp = 1'b0;
`endif
        do_reset();
        use_model  = 1'b0;
        in_mosi[0] = '{1'b1, 32'h0000_00A0, 1'b0};
        #1;
        cycle();
        cycle();
        in_mosi[0].tvalid = 1'b0;
        repeat (6) cycle();
        checks++; if (wd_err !== 1'b0) begin errors++; $display("FAIL wd_early got %b want 0", wd_err); end
        repeat (2) cycle();
        checks++; if (wd_err !== wd_exp) begin errors++; $display("FAIL wd_err got %b want %b", wd_err, wd_exp); end
        checks++; if (busy !== 1'b1 || grant !== 3'd0) begin errors++; $display("FAIL wd_lock got busy=%b grant=%0d want 1 0", busy, grant); end
        in_mosi[0] = '{1'b1, 32'h0000_00A1, 1'b1};
        cycle();
        in_mosi[0].tvalid = 1'b0;
        cycle();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wd_release got busy=%b want 0", busy); end
        checks++; if (wd_err !== wd_exp) begin errors++; $display("FAIL wd_sticky got %b want %b", wd_err, wd_exp); end
        use_model = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_round_robin();
        test_hold_off();
        test_backpressure();
        test_async_reset();
        test_watchdog();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL sim_timeout got running want finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule

`default_nettype wire
